nios_input_pio: RTL and testbench
=================================

NIOS_INPUT_PIO -- requirements
Module: nios_input_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of input port bits (1..32).
REQ-002 SHALL have parameter EDGE_TYPE, default 0, capture edge: 0 rising, 1 falling, 2 any.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1000, required stable-cycle count (2..65535); used only when debounce is compiled in.
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port address  input  2  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-008 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-009 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-010 SHALL have port in_port  input  WIDTH  asynchronous external inputs.
REQ-011 SHALL have port readdata  output  32  Avalon-MM read data, registered.
REQ-012 SHALL have port irq  output  1  interrupt request, active-high, level.

Function
REQ-013 SHALL pass in_port through a two-flop synchronizer (sync1, sync2) per bit.
REQ-014 SHALL define data_in = sync2 (debounce off) or the debounced value (debounce on).
REQ-015 SHALL register data_prev <= data_in each cycle; edge = data_in&~data_prev (rising), ~data_in&data_prev (falling), data_in^data_prev (any).
REQ-016 SHALL implement register map: addr 0 data (RO, data_in), addr 1 reserved (reads 0), addr 2 irq_mask (RW, WIDTH bits), addr 3 edge_capture (RW1C).
REQ-017 SHALL write irq_mask <= writedata[WIDTH-1:0] when chipselect && ~write_n && address==2.
REQ-018 SHALL clear edge_capture bit i when chipselect && ~write_n && address==3 && writedata[i]==1.
REQ-019 SHALL set edge_capture bit i on edge[i]; set wins over simultaneous clear of the same bit.
REQ-020 SHALL register readdata every cycle from address mux, zero-extended to 32 bits; read latency 1 cycle; chipselect not required for readdata update.
REQ-021 SHALL ignore writes to addresses 0 and 1.
REQ-022 SHALL drive irq = |(edge_capture & irq_mask), combinational from registers.
REQ-023 SHALL give latency in_port change (debounce off) -> edge_capture set and data readable at readdata: 3 rising edges after in_port is stable before edge 1.
REQ-024 SHALL keep edge_capture bits sticky until cleared; repeated edges on a set bit have no further effect.

Reset
REQ-025 SHALL, on reset_n low, asynchronously clear sync1, sync2, data_prev, debounce state, irq_mask, edge_capture, readdata to 0; irq therefore 0.
REQ-026 SHALL, after reset release with in_port high, report rising edges for those bits once propagated (data_prev starts 0).
REQ-027 SHALL abort any debounce count in progress on reset; no partial count survives.

Configuration
REQ-028 SHALL compile debounce logic only when macro NIOS_INPUT_PIO_DEBOUNCE_EN is defined.
REQ-029 SHALL, with macro: per bit, a 16-bit counter resets to 0 whenever sync2 differs from the debounced value's candidate; debounced bit updates to sync2 when sync2 held DEBOUNCE_CYCLES consecutive cycles; counter saturates, no wrap.
REQ-030 SHALL, without macro: data_in = sync2, no counters synthesized, DEBOUNCE_CYCLES ignored.

Verification
REQ-031 SHALL verify: reset, in_port=16'hA5A5 held -> read addr 0 returns 32'h0000A5A5 one cycle after address set; edge_capture=16'hA5A5.
REQ-032 SHALL verify: write irq_mask=16'h0001, rising edge on bit 0 -> irq high 3 cycles after input change; write 32'h1 to addr 3 -> irq low next cycle.
REQ-033 SHALL verify: clear of bit 3 coincident with new edge on bit 3 -> edge_capture[3] remains 1.
REQ-034 SHALL verify: EDGE_TYPE=1, bit 2 rises then falls -> edge_capture[2] set only after fall.
REQ-035 SHALL verify: with NIOS_INPUT_PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=8, glitch of 5 cycles -> no data change or capture; 10-cycle pulse -> capture set.
REQ-036 SHALL verify: reset_n asserted mid-debounce and with irq high -> irq, readdata, edge_capture go 0 immediately without clock.

Source files
------------

// File: rtl/nios_input_pio.sv
// Avalon-MM input PIO: synchronized inputs, edge capture with RW1C clear, masked level irq.
// Define NIOS_INPUT_PIO_DEBOUNCE_EN to add a per-bit stable-count debouncer after the synchronizer.
module nios_input_pio #(
    parameter int WIDTH           = 16,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_prev_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] clear_bits;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;
    logic             unused_wd;

    assign unused_wd = &{1'b0, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

`ifdef NIOS_INPUT_PIO_DEBOUNCE_EN
    // Counter value at which the candidate has been seen DEBOUNCE_CYCLES times in a row.
    localparam logic [15:0] STABLE_LAST = 16'(DEBOUNCE_CYCLES - 2);

    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [15:0]      cnt_q [WIDTH];
    logic [15:0]      cnt_d [WIDTH];

    always_comb begin
        cand_d = cand_q;
        deb_d  = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] != cand_q[i]) begin
                cand_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                if (cnt_q[i] != 16'hFFFF) begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
                if (cnt_q[i] >= STABLE_LAST) begin
                    deb_d[i] = cand_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_q <= '0;
            deb_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cand_q <= cand_d;
            deb_q  <= deb_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign data_in = deb_q;
`else
    assign data_in = sync2_q;
`endif

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_det = data_in & ~data_prev_q;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_det = ~data_in & data_prev_q;
        end else begin : g_any
            assign edge_det = data_in ^ data_prev_q;
        end
    endgenerate

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        irq_mask_d = irq_mask_q;
        if (wr_en && address == 2'd2) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        clear_bits = '0;
        if (wr_en && address == 2'd3) begin
            clear_bits = writedata[WIDTH-1:0];
        end
        // A new edge in the same cycle as its clear keeps the bit set.
        edge_capture_d = (edge_capture_q & ~clear_bits) | edge_det;

        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = data_in;
            2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edge_capture_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_prev_q    <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
        end else begin
            data_prev_q    <= data_in;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_nios_input_pio.sv
// Directed bench for nios_input_pio: a rising-edge and a falling-edge instance share the bus.
// With NIOS_INPUT_PIO_DEBOUNCE_EN defined only the debounce and reset sequences run.
module tb_nios_input_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [15:0] in_port;
    logic [31:0] rd_rise, rd_fall;
    logic        irq_rise, irq_fall;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nios_input_pio #(.WIDTH(16), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(8)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_rise), .irq(irq_rise)
    );

    nios_input_pio #(.WIDTH(16), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(8)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_fall), .irq(irq_fall)
    );

    typedef struct {
        logic [15:0] in_val;
        logic [15:0] mask;
        logic [15:0] cap;
        logic        irq;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] r_rise, output logic [31:0] r_fall);
        address = a;
        tick();
        r_rise = rd_rise;
        r_fall = rd_fall;
    endtask

    task automatic async_reset_check(input logic [31:0] rd_before);
        chk("pre_reset_irq", {31'b0, irq_rise}, 32'h1);
        chk("pre_reset_readdata", rd_rise, rd_before);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_irq", {31'b0, irq_rise}, 32'h0);
        chk("async_reset_irq_fall", {31'b0, irq_fall}, 32'h0);
        chk("async_reset_readdata", rd_rise, 32'h0);
        chk("async_reset_edge_capture", {16'h0, u_rise.edge_capture_q}, 32'h0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] r0, r1;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

`ifdef NIOS_INPUT_PIO_DEBOUNCE_EN
        in_port = 16'h0000;
        #22;
        chk("reset_readdata", rd_rise, 32'h0);
        release_reset();

        // 5-cycle glitch is shorter than the 8-cycle stable requirement
        in_port[1] = 1'b1;
        tick(5);
        in_port[1] = 1'b0;
        tick(20);
        rd(2'd0, r0, r1);
        chk("glitch_data", r0, 32'h0);
        rd(2'd3, r0, r1);
        chk("glitch_capture", r0, 32'h0);

        in_port[1] = 1'b1;
        tick(10);
        in_port[1] = 1'b0;
        tick(20);
        rd(2'd3, r0, r1);
        chk("pulse_capture_rise", r0, 32'h2);
        chk("pulse_capture_fall", r1, 32'h2);
        rd(2'd0, r0, r1);
        chk("pulse_data_after", r0, 32'h0);

        // reset in the middle of a debounce count must restart it from scratch
        wr(2'd2, 32'h0000_FFFF);
        address = 2'd3;
        tick();
        in_port[1] = 1'b1;
        tick(5);
        async_reset_check(32'h2);
        tick(3);
        release_reset();
        tick(6);
        rd(2'd0, r0, r1);
        chk("debounce_restart_early", r0, 32'h0);
        tick(10);
        rd(2'd0, r0, r1);
        chk("debounce_restart_done", r0, 32'h2);
`else
        vecs[0] = '{16'h0000, 16'hFFFF, 16'h0000, 1'b0};
        vecs[1] = '{16'h00FF, 16'h0F00, 16'h00FF, 1'b0};
        vecs[2] = '{16'h0FF0, 16'h0F00, 16'h0F00, 1'b1};
        vecs[3] = '{16'hFFFF, 16'h8000, 16'hF00F, 1'b1};
        vecs[4] = '{16'h1234, 16'hFFFF, 16'h0000, 1'b0};
        vecs[5] = '{16'h8001, 16'h0001, 16'h8001, 1'b1};

        in_port = 16'hA5A5;
        #22;
        chk("reset_readdata", rd_rise, 32'h0);
        chk("reset_irq", {31'b0, irq_rise}, 32'h0);
        release_reset();
        tick(3);
        rd(2'd0, r0, r1);
        chk("data_a5a5", r0, 32'h0000_A5A5);
        rd(2'd3, r0, r1);
        chk("capture_a5a5", r0, 32'h0000_A5A5);
        chk("capture_fall_none", r1, 32'h0);
        chk("irq_masked_off", {31'b0, irq_rise}, 32'h0);

        wr(2'd3, 32'h0000_FFFF);
        rd(2'd3, r0, r1);
        chk("capture_cleared", r0, 32'h0);
        wr(2'd2, 32'hFFFF_0001);
        rd(2'd2, r0, r1);
        chk("mask_write", r0, 32'h1);
        wr(2'd0, 32'h0000_FFFF);
        wr(2'd1, 32'h0000_FFFF);
        rd(2'd1, r0, r1);
        chk("reserved_reads_zero", r0, 32'h0);
        rd(2'd0, r0, r1);
        chk("data_write_ignored", r0, 32'h0000_A5A5);

        // irq three edges after a rising input on bit 0, gone one edge after RW1C
        in_port[0] = 1'b0;
        tick(4);
        chk("irq_before_edge", {31'b0, irq_rise}, 32'h0);
        in_port[0] = 1'b1;
        tick();
        chk("irq_lat_1", {31'b0, irq_rise}, 32'h0);
        tick();
        chk("irq_lat_2", {31'b0, irq_rise}, 32'h0);
        tick();
        chk("irq_lat_3", {31'b0, irq_rise}, 32'h1);
        wr(2'd3, 32'h1);
        chk("irq_after_clear", {31'b0, irq_rise}, 32'h0);

        // clear of bit 3 on the same edge that captures a new bit-3 edge
        in_port[3] = 1'b1;
        tick(3);
        rd(2'd3, r0, r1);
        chk("bit3_first_capture", r0, 32'h8);
        in_port[3] = 1'b0;
        tick(3);
        in_port[3] = 1'b1;
        tick(2);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd3;
        writedata  = 32'h8;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd(2'd3, r0, r1);
        chk("set_wins_over_clear", r0, 32'h8);
        wr(2'd3, 32'h8);
        rd(2'd3, r0, r1);
        chk("bit3_plain_clear", r0, 32'h0);

        for (int v = 0; v < 6; v++) begin
            wr(2'd3, 32'h0000_FFFF);
            wr(2'd2, {16'h0, vecs[v].mask});
            in_port = vecs[v].in_val;
            tick(3);
            chk($sformatf("vec%0d_irq", v), {31'b0, irq_rise}, {31'b0, vecs[v].irq});
            rd(2'd0, r0, r1);
            chk($sformatf("vec%0d_data", v), r0, {16'h0, vecs[v].in_val});
            rd(2'd2, r0, r1);
            chk($sformatf("vec%0d_mask", v), r0, {16'h0, vecs[v].mask});
            rd(2'd3, r0, r1);
            chk($sformatf("vec%0d_capture", v), r0, {16'h0, vecs[v].cap});
        end

        // falling-edge instance: bit 2 rises then falls
        wr(2'd3, 32'h0000_FFFF);
        in_port[2] = 1'b1;
        tick(4);
        rd(2'd3, r0, r1);
        chk("fall_after_rise", r1, 32'h0);
        chk("rise_inst_bit2", r0, 32'h4);
        in_port[2] = 1'b0;
        tick(4);
        rd(2'd3, r0, r1);
        chk("fall_after_fall", r1, 32'h4);

        wr(2'd2, 32'h0000_FFFF);
        address = 2'd3;
        tick();
        async_reset_check(32'h4);
        tick(2);
        release_reset();
        rd(2'd2, r0, r1);
        chk("mask_after_reset", r0, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
